sram_slave_bb: RTL
==================

Name: sram_slave_bb

Overview:
- Parametrised successor to the DPI word memory: an on-chip word-addressed RAM behind a valid/ready request channel and a valid/ready response channel.
- Adds byte-strobe writes, configurable fixed access latency, address-range checking with an error response, and response backpressure.
- Sits between the core's LSU/IFU memory port and the simulation top, replacing direct combinational/negedge DPI access with a clean synchronous slave.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8, power of two.
- ADDR_WIDTH, 32, byte address width.
- DEPTH, 1024, number of words; power of two.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 1, cycles from request acceptance to `resp_valid`; range 0..15.

Ports:
- clock, in, 1, single clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, slave can accept a request.
- req_addr, in, ADDR_WIDTH, byte address; low log2(DATA_WIDTH/8) bits ignored.
- req_wen, in, 1, 1 = write, 0 = read.
- req_wdata, in, DATA_WIDTH, write data.
- req_wstrb, in, DATA_WIDTH/8, byte write enables.
- resp_valid, out, 1, response present.
- resp_ready, in, 1, master accepts response.
- resp_rdata, out, DATA_WIDTH, read data; for writes, the word value before the write.
- resp_err, out, 1, address was out of range.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State becomes IDLE.
  - req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - Latency counter = 0.
  - Storage array is not cleared.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready = 1.
  - On `req_valid && req_ready` at edge N: latch addr, wen, wdata and wstrb.
  - If LATENCY == 0, go to RESP at edge N. Otherwise load counter = LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready = 0.
  - Counter decrements each edge.
  - At the edge where counter == 0, go to RESP.
  - Result: resp_valid first high in cycle N+1+LATENCY (N+1 when LATENCY == 0).
- Entry to RESP performs the access on that same edge:
  - resp_rdata ← old word. A read-and-write in one transaction returns pre-write data.
  - If wen, for each byte i with wstrb[i] == 1, word byte i ← wdata byte i. Other bytes are untouched.
  - wstrb == 0 with wen == 1 is legal: no bytes change, response is still returned.
- RESP:
  - resp_valid = 1; req_ready = 0.
  - resp_rdata and resp_err stay stable until the handshake.
  - On `resp_valid && resp_ready`, go to IDLE. The next request can be accepted in the following cycle; there is no back-to-back overlap.
- Range check:
  - Index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8).
  - Out of range if addr < BASE_ADDR or index >= DEPTH.
  - Out of range: no storage write, resp_rdata = 0, resp_err = 1.
  - In range: resp_err = 0.
  - Subtraction wraps at ADDR_WIDTH bits; addr < BASE_ADDR is detected by comparison, not by wrap.
- req_valid while busy is ignored; the master must hold it until it sees req_ready.
- Reset mid-transaction:
  - In WAIT: the transaction is dropped and no write occurs.
  - In RESP: the write has already committed; the response is lost.
- A write immediately followed by a read of the same address returns the new data.

Decomposition:
- Package `sram_bb_pkg` holds:
  - the FSM state enum (IDLE/WAIT/RESP);
  - the localparams STRB_WIDTH = DATA_WIDTH/8 and OFFSET_BITS = log2(STRB_WIDTH);
  - a typedef for the latched request struct.
- One sub-module, `sram_bb_array`: a synchronous DEPTH×DATA_WIDTH array with a per-byte write mask and a read-before-write port. The FSM, range check and handshake stay in the top module.

Test Plan (DATA_WIDTH = 32, DEPTH = 1024, BASE = 0x8000_0000, LATENCY = 2):
- Write 0xDEADBEEF, wstrb = 0xF, to 0x8000_0010, then read 0x8000_0010 → write response resp_err = 0; read resp_rdata = 0xDEADBEEF; resp_valid rises 3 cycles after each acceptance.
- Write 0x0000_AA00 with wstrb = 0x2 to the same word → read returns 0xDEADAAEF; the write response's rdata = 0xDEADBEEF (pre-write).
- Read 0x8000_1000 (index 1024) and read 0x7FFF_FFFC → resp_err = 1, resp_rdata = 0; storage unchanged.
- Hold resp_ready = 0 for 5 cycles after resp_valid → resp_valid and resp_rdata stay stable; req_ready = 0; a req_valid pulse during the stall is ignored.
- Pull reset_n low during WAIT of a write of 0x12345678 to 0x8000_0020 → outputs reach reset values immediately; a later read of 0x8000_0020 returns the prior contents.
- Rerun with LATENCY = 0 → resp_valid high in the cycle after acceptance; read-after-write still correct.

Source files
------------

// File: rtl/sram_bb_pkg.sv
// Shared types and helpers for the sram_slave_bb word RAM slave.
package sram_bb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Geometry of the default 32-bit word configuration.
  localparam int DATA_WIDTH_DFLT = 32;
  localparam int STRB_WIDTH      = DATA_WIDTH_DFLT / 8;
  localparam int OFFSET_BITS     = $clog2(STRB_WIDTH);

  // Control attributes of the accepted request, held while the access is pending.
  typedef struct packed {
    logic wen;
    logic err;
  } req_t;

  function automatic int offset_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/sram_bb_array.sv
// DEPTH x DATA_WIDTH synchronous RAM with per-byte write mask; read returns the pre-write word.
module sram_bb_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                      clock,
  input  logic                      i_en,
  input  logic                      i_we,
  input  logic [$clog2(DEPTH)-1:0]  i_idx,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_wstrb,
  output logic [DATA_WIDTH-1:0]     o_rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_en) begin
      r_rdata <= r_mem[i_idx];
      if (i_we) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (i_wstrb[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_slave_bb.sv
// Word-addressed on-chip RAM slave: valid/ready request and response channels,
// fixed access latency, byte strobes and out-of-range error responses.
module sram_slave_bb
  import sram_bb_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    LATENCY    = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_wen,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = offset_bits(DATA_WIDTH);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = 4;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  req_t                 r_req;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]    r_wstrb;
  logic                 r_req_ready;
  logic                 r_resp_valid;
  logic                 r_resp_err;
  logic                 r_rd_ok;

  logic [ADDR_WIDTH-1:0] w_off;
  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_oor;
  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_cur_err;
  logic                  w_cur_wen;
  logic [IDX_W-1:0]      w_arr_idx;
  logic [DATA_WIDTH-1:0] w_arr_wdata;
  logic [STRB_W-1:0]     w_arr_wstrb;
  logic [DATA_WIDTH-1:0] w_arr_rdata;

  // Below-base addresses are caught by the compare; the wrapped offset alone would look huge but valid-shaped.
  assign w_off  = req_addr - BASE_ADDR;
  assign w_word = w_off >> OFF_W;
  assign w_oor  = (req_addr < BASE_ADDR) || (w_word >= ADDR_WIDTH'(DEPTH));

  assign w_accept = req_valid && r_req_ready;

  // With zero latency the access happens on the accepting edge, so it uses the live request.
  assign w_enter_resp = (LATENCY == 0) ? w_accept : ((r_state == WAIT) && (r_cnt == '0));
  assign w_cur_err    = (LATENCY == 0) ? w_oor : r_req.err;
  assign w_cur_wen    = (LATENCY == 0) ? req_wen : r_req.wen;
  assign w_arr_idx    = (LATENCY == 0) ? w_word[IDX_W-1:0] : r_idx;
  assign w_arr_wdata  = (LATENCY == 0) ? req_wdata : r_wdata;
  assign w_arr_wstrb  = (LATENCY == 0) ? req_wstrb : r_wstrb;

  sram_bb_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clock   (clock),
    .i_en    (w_enter_resp && !w_cur_err),
    .i_we    (w_cur_wen),
    .i_idx   (w_arr_idx),
    .i_wdata (w_arr_wdata),
    .i_wstrb (w_arr_wstrb),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_idx   <= w_word[IDX_W-1:0];
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rd_ok      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req       <= '{wen: req_wen, err: w_oor};
            r_req_ready <= 1'b0;
            if (LATENCY == 0) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= w_oor;
              r_rd_ok      <= !w_oor;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= r_req.err;
            r_rd_ok      <= !r_req.err;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Error responses and the post-reset state force zero data over the array's last read.
  assign resp_rdata = r_rd_ok ? w_arr_rdata : '0;
  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;

endmodule
